// File: rtl/ics_sample_cache.sv
// ics_sample_cache: direct-mapped read cache for ICS2115 sample fetches in front of SDRAM.
// Define ICS_CACHE_STATS_EN to add the saturating hit_cnt/miss_cnt counters.
module ics_sample_cache #(
    parameter int LINES  = 64,
    parameter int ADDR_W = 29
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_rd,
    input  logic [ADDR_W-1:0] req_addr,
    output logic [63:0]       req_dout,
    output logic              req_ready,
    input  logic              flush,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [63:0]       mem_dout,
    input  logic              mem_busy,
    input  logic              mem_dout_ready
`ifdef ICS_CACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP} state_t;

    state_t            state, state_d;
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem [LINES];
    logic [63:0]       data_mem [LINES];
    logic [TAG_W-1:0]  rd_tag;
    logic [63:0]       rd_data;
    logic [ADDR_W-1:0] addr_q;
    logic [IDX_W-1:0]  idx_q;
    logic              kill, hit, fill, install;

    // a flush on the LOOKUP edge must already count, hence the !flush term
    always_comb begin
        idx_q   = addr_q[IDX_W-1:0];
        hit     = state == LOOKUP && valid[idx_q] && !flush && rd_tag == addr_q[ADDR_W-1:IDX_W];
        fill    = state == MISS_WAIT && mem_dout_ready;
        install = fill && !kill;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:      state_d = req_rd ? LOOKUP : IDLE;
            LOOKUP:    state_d = hit ? RESP : MISS_REQ;
            MISS_REQ:  state_d = mem_busy ? MISS_REQ : MISS_WAIT;
            MISS_WAIT: state_d = mem_dout_ready ? RESP : MISS_WAIT;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = state == RESP;
        mem_rd    = state == MISS_WAIT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            valid    <= '0;
            req_dout <= '0;
            mem_addr <= '0;
            addr_q   <= '0;
            kill     <= 1'b0;
        end else begin
            state <= state_d;
            if (state == IDLE && req_rd) addr_q <= req_addr;
            if (hit) req_dout <= rd_data;
            else if (fill) req_dout <= mem_dout;
            if (state == MISS_REQ && !mem_busy) mem_addr <= addr_q;
            if (flush) valid <= '0;
            else if (install) valid[idx_q] <= 1'b1;
            // a flush while the fill is outstanding makes the returning word stale
            kill <= state == RESP ? 1'b0 : kill || (flush && (state == MISS_REQ || state == MISS_WAIT));
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req_rd) begin
            rd_tag  <= tag_mem[req_addr[IDX_W-1:0]];
            rd_data <= data_mem[req_addr[IDX_W-1:0]];
        end
        if (install) begin
            tag_mem[idx_q]  <= addr_q[ADDR_W-1:IDX_W];
            data_mem[idx_q] <= mem_dout;
        end
    end

`ifdef ICS_CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == LOOKUP) begin
            if (hit && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            if (!hit && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ics_sample_cache.sv
// tb_ics_sample_cache: table-driven fetches against an SDRAM responder model, checked via a response scoreboard.
module tb_ics_sample_cache;
    logic        clk = 1'b0;
    logic        reset, req_rd, flush, mem_busy, mem_dout_ready;
    logic [28:0] req_addr;
    logic [63:0] req_dout, mem_dout;
    logic        req_ready, mem_rd;
    logic [28:0] mem_addr;
`ifdef ICS_CACHE_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    ics_sample_cache #(.LINES(64), .ADDR_W(29)) dut (
        .clk(clk), .reset(reset), .req_rd(req_rd), .req_addr(req_addr),
        .req_dout(req_dout), .req_ready(req_ready), .flush(flush),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .mem_busy(mem_busy), .mem_dout_ready(mem_dout_ready)
`ifdef ICS_CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [28:0] addr;
        int          busy;
        int          flush_at;
        int          miss;
    } vec_t;

    int          vectors = 0;
    int          errors  = 0;
    int          mem_reqs = 0;
    int          mem_lat = 5;
    logic [63:0] sb[$];
    vec_t        tv[$];

    function automatic logic [63:0] mdata(input logic [28:0] a);
        return a == 29'h100 ? 64'h1111_2222_3333_4444 : {6'h2A, a, a ^ 29'h0ABC_DEF1};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        mem_dout_ready = 1'b0;
        mem_dout = '0;
        forever begin
            @(negedge clk);
            if (mem_rd) begin
                logic [28:0] a;
                a = mem_addr;
                mem_reqs++;
                repeat (mem_lat - 1) @(negedge clk);
                mem_dout = mdata(a);
                mem_dout_ready = 1'b1;
                @(negedge clk);
                mem_dout_ready = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (req_ready) begin
            if (sb.size() == 0) chk("unexpected_req_ready", 64'd1, 64'd0);
            else chk("req_dout", req_dout, sb.pop_front());
        end
    end

    task automatic fetch(input vec_t v);
        int cyc, r0;
        bit bad, rd_seen;
        sb.push_back(mdata(v.addr));
        r0 = mem_reqs;
        bad = 0;
        rd_seen = 0;
        cyc = 1;
        @(posedge clk); #1;
        req_rd = 1'b1;
        req_addr = v.addr;
        mem_busy = v.busy > 0;
        forever begin
            @(negedge clk);
            flush = cyc == v.flush_at;
            if (req_ready || cyc > 200) break;
            if ((mem_busy && mem_rd) || (rd_seen && !mem_rd)) bad = 1;
            rd_seen |= mem_rd;
            if (cyc == v.busy) mem_busy = 1'b0;
            cyc++;
        end
        @(posedge clk); #1;
        req_rd = 1'b0;
        flush = 1'b0;
        mem_busy = 1'b0;
        chk("timeout", 64'(cyc > 200), 64'd0);
        chk("mem_rd_count", 64'(mem_reqs - r0), 64'(v.miss));
        chk("mem_rd_protocol", 64'(bad), 64'd0);
        if (v.miss == 0) chk("hit_latency", 64'(cyc), 64'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tv.push_back('{29'h100, 0, 0, 1});
        tv.push_back('{29'h100, 0, 0, 0});
        tv.push_back('{29'h140, 0, 0, 1});
        tv.push_back('{29'h100, 0, 0, 1});
        tv.push_back('{29'h13F, 0, 0, 1});
        tv.push_back('{29'h13F, 0, 0, 0});
        tv.push_back('{29'h1FFF_FFFF, 0, 0, 1});
        tv.push_back('{29'h1FFF_FFFF, 0, 0, 0});
        tv.push_back('{29'h300, 10, 0, 1});
        tv.push_back('{29'h300, 0, 0, 0});
        tv.push_back('{29'h180, 0, 0, 1});
        tv.push_back('{29'h180, 0, 2, 1});
        tv.push_back('{29'h180, 0, 0, 0});
        tv.push_back('{29'h200, 0, 4, 1});
        tv.push_back('{29'h200, 0, 0, 1});
        tv.push_back('{29'h200, 0, 0, 0});

        reset = 1'b1;
        req_rd = 1'b0;
        req_addr = '0;
        flush = 1'b0;
        mem_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_req_dout", req_dout, 64'd0);
        chk("reset_mem_rd", 64'(mem_rd), 64'd0);
        chk("reset_mem_addr", 64'(mem_addr), 64'd0);

        for (int i = 0; i < tv.size(); i++) begin
            fetch(tv[i]);
`ifdef ICS_CACHE_STATS_EN
            if (i == 1) begin
                chk("hit_cnt_after_2", 64'(hit_cnt), 64'd1);
                chk("miss_cnt_after_2", 64'(miss_cnt), 64'd1);
            end
`endif
        end

        // reset while the fill is outstanding; the late data pulse must be ignored
        mem_lat = 8;
        @(posedge clk); #1;
        req_rd = 1'b1;
        req_addr = 29'h400;
        n = 0;
        while (!mem_rd && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_mem_rd_seen", 64'(mem_rd), 64'd1);
        reset = 1'b1;
        req_rd = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_req_dout", req_dout, 64'd0);
        chk("abort_mem_rd_idle", 64'(mem_rd), 64'd0);
        mem_lat = 5;
        fetch('{29'h400, 0, 0, 1});
`ifdef ICS_CACHE_STATS_EN
        chk("hit_cnt_after_reset", 64'(hit_cnt), 64'd0);
        chk("miss_cnt_after_reset", 64'(miss_cnt), 64'd1);
`endif
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
